// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the two-master round-robin bus arbiter.
// Grant selection is a pure function so the tie-break rule lives in one place.
package bus_arbiter_pkg;

  localparam int         REG_BUS         = 32;
  localparam logic [7:0] ARB_TIMEOUT_DEF = 8'd255;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_GNT0 = 2'b01,
    ARB_GNT1 = 2'b10
  } arb_state_t;

  typedef struct packed {
    logic [REG_BUS-1:0] addr;
    logic [31:0]        data;
    logic               select;
    logic               we;
  } mreq_t;

  // On a tie the master that did not own the bus last time wins.
  function automatic arb_state_t pick_grant(input logic sel0, input logic sel1, input logic last);
    arb_state_t res;
    res = ARB_IDLE;
    if (sel0 && sel1) begin
      res = last ? ARB_GNT0 : ARB_GNT1;
    end else if (sel0) begin
      res = ARB_GNT0;
    end else if (sel1) begin
      res = ARB_GNT1;
    end
    return res;
  endfunction

endpackage

// File: rtl/bus_arbiter.sv
// Round-robin arbiter: two masters onto one slave bus, grant 1 cycle after request.
// Ack/err/data are combinational from the slave; a silent slave is cut off after TIMEOUT cycles.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter logic [7:0] TIMEOUT = ARB_TIMEOUT_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,

  input  logic [REG_BUS-1:0] m0_addr_i,
  input  logic [31:0]        m0_data_i,
  input  logic               m0_select_i,
  input  logic               m0_we_i,
  output logic [31:0]        m0_data_o,
  output logic               m0_ack_o,
  output logic               m0_err_o,

  input  logic [REG_BUS-1:0] m1_addr_i,
  input  logic [31:0]        m1_data_i,
  input  logic               m1_select_i,
  input  logic               m1_we_i,
  output logic [31:0]        m1_data_o,
  output logic               m1_ack_o,
  output logic               m1_err_o,

  output logic [REG_BUS-1:0] bus_addr_o,
  output logic [31:0]        bus_data_o,
  output logic               bus_select_o,
  output logic               bus_we_o,
  input  logic [31:0]        bus_data_i,
  input  logic               bus_ack_i
);

  arb_state_t state, state_nxt;
  logic       last, last_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;

  mreq_t req0, req1, cur;
  logic  granted, gnt1, cur_sel, timeout_hit, done;

  assign req0 = '{addr: m0_addr_i, data: m0_data_i, select: m0_select_i, we: m0_we_i};
  assign req1 = '{addr: m1_addr_i, data: m1_data_i, select: m1_select_i, we: m1_we_i};

  always_comb begin
    granted     = (state == ARB_GNT0) || (state == ARB_GNT1);
    gnt1        = (state == ARB_GNT1);
    cur         = gnt1 ? req1 : req0;
    cur_sel     = granted && cur.select;
    // A slave ack arriving on the last allowed cycle still completes normally.
    timeout_hit = cur_sel && !bus_ack_i && (wait_cnt == TIMEOUT - 8'd1);
    done        = cur_sel && (bus_ack_i || timeout_hit);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= ARB_IDLE;
      last     <= 1'b1;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      last     <= last_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    last_nxt     = last;
    wait_cnt_nxt = wait_cnt;
    case (state)
      ARB_IDLE: begin
        state_nxt    = pick_grant(req0.select, req1.select, last);
        wait_cnt_nxt = '0;
      end
      ARB_GNT0, ARB_GNT1: begin
        if (!cur.select || done) begin
          state_nxt    = ARB_IDLE;
          last_nxt     = gnt1;
          wait_cnt_nxt = '0;
        end else begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
      end
      default: begin
        state_nxt    = ARB_IDLE;
        wait_cnt_nxt = '0;
      end
    endcase
  end

  always_comb begin
    bus_addr_o   = '0;
    bus_data_o   = '0;
    bus_we_o     = 1'b0;
    bus_select_o = 1'b0;
    m0_data_o    = '0;
    m0_ack_o     = 1'b0;
    m0_err_o     = 1'b0;
    m1_data_o    = '0;
    m1_ack_o     = 1'b0;
    m1_err_o     = 1'b0;
    if (granted) begin
      bus_addr_o   = cur.addr;
      bus_data_o   = cur.data;
      bus_we_o     = cur.we;
      bus_select_o = cur_sel && !timeout_hit;
      if (gnt1) begin
        m1_data_o = bus_data_i;
        m1_ack_o  = done;
        m1_err_o  = timeout_hit;
      end else begin
        m0_data_o = bus_data_i;
        m0_ack_o  = done;
        m0_err_o  = timeout_hit;
      end
    end
  end

  a_one_ack: assert property (@(posedge clk_i) disable iff (!rst_i) !(m0_ack_o && m1_ack_o));
  a_err0_ack: assert property (@(posedge clk_i) disable iff (!rst_i) m0_err_o |-> m0_ack_o);
  a_err1_ack: assert property (@(posedge clk_i) disable iff (!rst_i) m1_err_o |-> m1_ack_o);
  a_sel_gnt: assert property (@(posedge clk_i) disable iff (!rst_i) bus_select_o |-> granted);
  a_cnt_rng: assert property (@(posedge clk_i) disable iff (!rst_i) wait_cnt < TIMEOUT);

endmodule
